alu_sequencer: RTL and testbench

Multi-cycle control sequencer that drives the ALU. It fetches 32-bit instructions over a valid/ready handshake and decodes them into ALU opcode and register addresses. It latches the ALU Z/N result flags and uses them to resolve conditional branches, which update the program counter. It sits between instruction memory, the register file and the ALU, and issues the opcodes that the ALU consumes.

---
 rtl/alu_sequencer_if.sv | 43 ++++
 rtl/alu_sequencer.sv | 130 +++++++++++++
 tb/tb_alu_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Sequencer <-> instruction memory / register file / ALU bus.
// The illegal flag exists only when SEQ_ILLEGAL_TRAP_EN is defined.
interface alu_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int REG_AW = 6
);
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        alu_opcode;
    logic              alu_z;
    logic              alu_n;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic [REG_AW-1:0] rd_addr;
    logic [31:0]       rs_data;
    logic              reg_we;
    logic              flag_z;
    logic              flag_n;
    logic              halted;
`ifdef SEQ_ILLEGAL_TRAP_EN
    logic              illegal;
`endif

    modport master (
        input  instr, instr_valid, alu_z, alu_n, rs_data,
        output instr_ready, pc, alu_opcode, rs_addr, rt_addr, rd_addr,
               reg_we, flag_z, flag_n, halted
`ifdef SEQ_ILLEGAL_TRAP_EN
        , output illegal
`endif
    );

    modport slave (
        output instr, instr_valid, alu_z, alu_n, rs_data,
        input  instr_ready, pc, alu_opcode, rs_addr, rt_addr, rd_addr,
               reg_we, flag_z, flag_n, halted
`ifdef SEQ_ILLEGAL_TRAP_EN
        , input illegal
`endif
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer driving the ALU.
// Optional SEQ_ILLEGAL_TRAP_EN: undefined opcodes halt and set a sticky illegal flag.
//
// state  | meaning
// FETCH  | instr_ready high, waiting for instr_valid handshake
// DECODE | register addresses presented, ALU idle
// EXEC   | ALU opcode driven, branches/jumps resolved, flags captured
// WB     | opcode held, reg_we pulse, pc advances
// HALT   | frozen until reset
module alu_sequencer #(
    parameter int ADDR_W = 8,
    parameter int REG_AW = 6
) (
    input  logic           clk,
    input  logic           rst,
    alu_sequencer_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_BRZ  = 4'b1001;
    localparam logic [3:0] OP_BRN  = 4'b1010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t            state;
    logic [3:0]        op;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic              unused_bits;

    assign pc_inc      = bus.pc + ADDR_W'(1);
    assign target      = bus.rs_data[ADDR_W-1:0];
    assign unused_bits = ^{bus.instr[9:0], bus.rs_data[31:ADDR_W]};

    function automatic logic is_alu(input logic [3:0] o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_INC) || (o == OP_NOT);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= FETCH;
            op              <= OP_NOP;
            bus.pc          <= '0;
            bus.alu_opcode  <= OP_NOP;
            bus.rs_addr     <= '0;
            bus.rt_addr     <= '0;
            bus.rd_addr     <= '0;
            bus.reg_we      <= 1'b0;
            bus.flag_z      <= 1'b0;
            bus.flag_n      <= 1'b0;
            bus.halted      <= 1'b0;
            bus.instr_ready <= 1'b0;
`ifdef SEQ_ILLEGAL_TRAP_EN
            bus.illegal     <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH: begin
                    if (bus.instr_valid && bus.instr_ready) begin
                        op              <= bus.instr[31:28];
                        bus.rd_addr     <= REG_AW'(bus.instr[27:22]);
                        bus.rs_addr     <= REG_AW'(bus.instr[21:16]);
                        bus.rt_addr     <= REG_AW'(bus.instr[15:10]);
                        bus.instr_ready <= 1'b0;
                        state           <= DECODE;
                    end else begin
                        bus.instr_ready <= 1'b1;
                    end
                end
                DECODE: begin
                    bus.alu_opcode <= is_alu(op) ? op : OP_NOP;
                    state          <= EXEC;
                end
                EXEC: begin
                    // Most opcodes return straight to FETCH; ALU ops and halts override.
                    bus.alu_opcode  <= OP_NOP;
                    bus.instr_ready <= 1'b1;
                    state           <= FETCH;
                    case (op)
                        OP_ADD, OP_SUB, OP_INC, OP_NOT: begin
                            bus.alu_opcode  <= op;
                            bus.flag_z      <= bus.alu_z;
                            bus.flag_n      <= bus.alu_n;
                            bus.reg_we      <= 1'b1;
                            bus.instr_ready <= 1'b0;
                            state           <= WB;
                        end
                        OP_JMP: bus.pc <= target;
                        OP_BRZ: bus.pc <= bus.flag_z ? target : pc_inc;
                        OP_BRN: bus.pc <= bus.flag_n ? target : pc_inc;
                        OP_HALT: begin
                            bus.halted      <= 1'b1;
                            bus.instr_ready <= 1'b0;
                            state           <= HALT;
                        end
                        OP_NOP: bus.pc <= pc_inc;
                        default: begin
`ifdef SEQ_ILLEGAL_TRAP_EN
                            bus.halted      <= 1'b1;
                            bus.illegal     <= 1'b1;
                            bus.instr_ready <= 1'b0;
                            state           <= HALT;
`else
                            bus.pc <= pc_inc;
`endif
                        end
                    endcase
                end
                WB: begin
                    bus.reg_we      <= 1'b0;
                    bus.alu_opcode  <= OP_NOP;
                    bus.pc          <= pc_inc;
                    bus.instr_ready <= 1'b1;
                    state           <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed + randomized bench for alu_sequencer with a per-instruction reference model.
module tb_alu_sequencer;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    int   m_pc;
    bit   m_z;
    bit   m_n;

    logic [3:0] ops[$];

    alu_sequencer_if #(.ADDR_W(8), .REG_AW(6)) bus ();

    alu_sequencer #(.ADDR_W(8), .REG_AW(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int g = 0;
        while (bus.instr_ready !== 1'b1 && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        chk("ready_wait", {31'd0, bus.instr_ready}, 32'd1);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        m_pc = 0; m_z = 0; m_n = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one non-halting instruction and compare against the model.
    task automatic run_instr(input logic [3:0] op, input logic [5:0] rd, input logic [5:0] rs,
                             input logic [5:0] rt, input logic [31:0] rsd, input bit z, input bit n);
        int         lat = 1;
        int         we_cnt = 0;
        int         op_cycles = 0;
        logic [5:0] we_rd = '0;
        logic [3:0] seen_op = '0;
        bit         alu;
        wait_ready();
        bus.instr       = {op, rd, rs, rt, 10'($urandom)};
        bus.instr_valid = 1'b1;
        bus.rs_data     = rsd;
        bus.alu_z       = z;
        bus.alu_n       = n;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.instr       = $urandom;
        chk("rd_addr", 32'(bus.rd_addr), 32'(rd));
        chk("rs_addr", 32'(bus.rs_addr), 32'(rs));
        chk("rt_addr", 32'(bus.rt_addr), 32'(rt));
        while (bus.instr_ready !== 1'b1 && lat < 12) begin
            if (bus.reg_we === 1'b1) begin
                we_cnt++;
                we_rd = bus.rd_addr;
            end
            if (bus.alu_opcode !== 4'b0000) begin
                op_cycles++;
                seen_op = bus.alu_opcode;
            end
            @(posedge clk); #1;
            lat++;
        end
        alu = (op == 4'b0001) || (op == 4'b0111) || (op == 4'b0101) || (op == 4'b0110);
        if (alu) begin
            m_z  = z;
            m_n  = n;
            m_pc = (m_pc + 1) % 256;
        end else if (op == 4'b1000) begin
            m_pc = int'(rsd % 256);
        end else if (op == 4'b1001) begin
            m_pc = m_z ? int'(rsd % 256) : (m_pc + 1) % 256;
        end else if (op == 4'b1010) begin
            m_pc = m_n ? int'(rsd % 256) : (m_pc + 1) % 256;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
        chk("latency",   32'(lat),       alu ? 32'd4 : 32'd3);
        chk("reg_we_n",  32'(we_cnt),    alu ? 32'd1 : 32'd0);
        chk("op_cycles", 32'(op_cycles), alu ? 32'd2 : 32'd0);
        chk("seen_op",   32'(seen_op),   alu ? 32'(op) : 32'd0);
        chk("we_rd",     32'(we_rd),     alu ? 32'(rd) : 32'd0);
        chk("pc",        32'(bus.pc),    32'(m_pc));
        chk("flag_z",    32'(bus.flag_z), 32'(m_z));
        chk("flag_n",    32'(bus.flag_n), 32'(m_n));
    endtask

    // Handshake an instruction that will not return to FETCH.
    task automatic issue_and_settle(input logic [3:0] op, input bit hold_valid);
        wait_ready();
        bus.instr       = {op, 28'd0};
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = hold_valid;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b0;
        bus.instr = '0; bus.instr_valid = 1'b0; bus.rs_data = '0;
        bus.alu_z = 1'b0; bus.alu_n = 1'b0;
        m_pc = 0; m_z = 0; m_n = 0;
        #1 rst = 1'b1;
        #2;
        chk("rst_pc",     32'(bus.pc),          32'd0);
        chk("rst_ready",  32'(bus.instr_ready), 32'd0);
        chk("rst_halted", 32'(bus.halted),      32'd0);
        chk("rst_we",     32'(bus.reg_we),      32'd0);
        chk("rst_opcode", 32'(bus.alu_opcode),  32'd0);
        chk("rst_flags",  32'({bus.flag_z, bus.flag_n}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("idle_pc",    32'(bus.pc),          32'd0);
            chk("idle_ready", 32'(bus.instr_ready), 32'd1);
            chk("idle_we",    32'(bus.reg_we),      32'd0);
            chk("idle_flags", 32'({bus.flag_z, bus.flag_n}), 32'd0);
        end

        run_instr(4'b0001, 6'd3, 6'd1, 6'd2, 32'h0, 1'b1, 1'b0);
        run_instr(4'b0111, 6'd4, 6'd5, 6'd6, 32'h0, 1'b0, 1'b1);
        run_instr(4'b1010, 6'd0, 6'd7, 6'd0, 32'h0000_0040, 1'b0, 1'b0);
        run_instr(4'b0111, 6'd8, 6'd9, 6'd10, 32'h0, 1'b1, 1'b0);
        run_instr(4'b1010, 6'd0, 6'd7, 6'd0, 32'h0000_0040, 1'b0, 1'b1);
        run_instr(4'b1001, 6'd0, 6'd11, 6'd0, 32'h0000_0090, 1'b0, 1'b0);
        run_instr(4'b0001, 6'd12, 6'd13, 6'd14, 32'h0, 1'b0, 1'b0);
        run_instr(4'b1001, 6'd0, 6'd11, 6'd0, 32'h0000_0090, 1'b1, 1'b0);
        run_instr(4'b1000, 6'd0, 6'd1, 6'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_instr(4'b0000, 6'd0, 6'd0, 6'd0, 32'h0, 1'b1, 1'b1);
        run_instr(4'b1000, 6'd0, 6'd2, 6'd0, 32'hFFFF_FF12, 1'b0, 1'b0);
`ifndef SEQ_ILLEGAL_TRAP_EN
        run_instr(4'b1100, 6'd1, 6'd2, 6'd3, 32'h0000_0077, 1'b1, 1'b1);
`endif

`ifdef SEQ_ILLEGAL_TRAP_EN
        ops = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
`else
        ops = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'h2, 4'h3, 4'h4, 4'hB, 4'hD, 4'hE};
`endif
        for (int i = 0; i < 40; i++) begin
            run_instr(ops[$urandom_range(0, ops.size() - 1)], 6'($urandom), 6'($urandom),
                      6'($urandom), $urandom, 1'($urandom), 1'($urandom));
        end

        run_instr(4'b1000, 6'd0, 6'd0, 6'd0, 32'h0000_0005, 1'b0, 1'b0);
        issue_and_settle(4'b1111, 1'b1);
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", 32'(bus.halted),      32'd1);
            chk("halt_pc",     32'(bus.pc),          32'd5);
            chk("halt_ready",  32'(bus.instr_ready), 32'd0);
            chk("halt_we",     32'(bus.reg_we),      32'd0);
            chk("halt_opcode", 32'(bus.alu_opcode),  32'd0);
            chk("halt_flags",  32'({bus.flag_z, bus.flag_n}), 32'({m_z, m_n}));
            @(posedge clk); #1;
        end
        bus.instr_valid = 1'b0;
        do_reset();
        chk("halt_rst_pc",     32'(bus.pc),     32'd0);
        chk("halt_rst_halted", 32'(bus.halted), 32'd0);

        wait_ready();
        bus.instr       = {4'b0001, 6'd3, 6'd1, 6'd2, 10'd0};
        bus.instr_valid = 1'b1;
        bus.alu_z       = 1'b1;
        bus.alu_n       = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wb_we",    32'(bus.reg_we), 32'd1);
        chk("wb_flagz", 32'(bus.flag_z), 32'd1);
        do_reset();
        chk("wbrst_we",    32'(bus.reg_we), 32'd0);
        chk("wbrst_flags", 32'({bus.flag_z, bus.flag_n}), 32'd0);
        chk("wbrst_pc",    32'(bus.pc),     32'd0);

`ifdef SEQ_ILLEGAL_TRAP_EN
        chk("ill_rst", 32'(bus.illegal), 32'd0);
        run_instr(4'b1000, 6'd0, 6'd0, 6'd0, 32'h0000_0007, 1'b0, 1'b0);
        issue_and_settle(4'b1100, 1'b0);
        chk("ill_flag",   32'(bus.illegal), 32'd1);
        chk("ill_halted", 32'(bus.halted),  32'd1);
        chk("ill_pc",     32'(bus.pc),      32'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
